window_sequencer: RTL and testbench

WINDOW_SEQUENCER -- requirements
Module: window_sequencer

---
 rtl/window_sequencer.sv | 93 +++++++++
 tb/tb_window_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/window_sequencer.sv
// window_sequencer: frame raster sequencer driving a sliding-window generator.
// Tracks pixel coordinates, gates upstream pixels on downstream readiness, flags complete windows.
module window_sequencer #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int WIN_WIDTH    = 3,
  parameter int WIN_HEIGHT   = 3,
  parameter int COORD_WIDTH  = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   out_ready,
  output logic                   win_en,
  output logic                   win_valid,
  output logic [COORD_WIDTH-1:0] win_x,
  output logic [COORD_WIDTH-1:0] win_y,
  output logic                   busy,
  output logic                   frame_done
);
  localparam logic [COORD_WIDTH-1:0] COL_MAX = COORD_WIDTH'(FRAME_WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] ROW_MAX = COORD_WIDTH'(FRAME_HEIGHT - 1);
  localparam logic [COORD_WIDTH-1:0] COL_MIN = COORD_WIDTH'(WIN_WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] ROW_MIN = COORD_WIDTH'(WIN_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t                   state_q, state_d;
  logic [COORD_WIDTH-1:0]   col_q, col_d, row_q, row_d;
  logic [COORD_WIDTH-1:0]   win_x_q, win_x_d, win_y_q, win_y_d;
  logic                     win_valid_q, win_valid_d;
  logic                     accept, last_col, last_row;

  assign in_ready   = (state_q == ACTIVE) & out_ready;
  assign accept     = in_valid & in_ready;
  assign win_en     = accept;
  assign last_col   = col_q == COL_MAX;
  assign last_row   = row_q == ROW_MAX;
  assign win_valid  = win_valid_q;
  assign win_x      = win_x_q;
  assign win_y      = win_y_q;
  assign busy       = state_q != IDLE;
  assign frame_done = state_q == DONE;

  // Abort outranks everything; the final pixel clears the counters so they never overrun.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    win_x_d     = win_x_q;
    win_y_d     = win_y_q;
    win_valid_d = 1'b0;
    if (abort) begin
      state_d = IDLE;
      col_d   = '0;
      row_d   = '0;
    end else if (state_q == IDLE) begin
      state_d = start ? ACTIVE : IDLE;
      col_d   = start ? '0 : col_q;
      row_d   = start ? '0 : row_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else if (accept) begin
      win_x_d     = col_q;
      win_y_d     = row_q;
      win_valid_d = (col_q >= COL_MIN) && (row_q >= ROW_MIN);
      col_d       = last_col ? '0 : col_q + 1'b1;
      row_d       = last_col ? (last_row ? '0 : row_q + 1'b1) : row_q;
      state_d     = (last_col && last_row) ? DONE : ACTIVE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      win_x_q     <= '0;
      win_y_q     <= '0;
      win_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_x_q     <= win_x_d;
      win_y_q     <= win_y_d;
      win_valid_q <= win_valid_d;
    end
  end
endmodule

// File: tb/tb_window_sequencer.sv
// tb_window_sequencer: directed bench for window_sequencer on an 8x4 frame with a 3x3 window.
module tb_window_sequencer;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, win_en, win_valid, busy, frame_done;
  logic [10:0] win_x, win_y;
  int compared = 0, mismatched = 0;

  window_sequencer #(.FRAME_WIDTH(8), .FRAME_HEIGHT(4), .WIN_WIDTH(3), .WIN_HEIGHT(3), .COORD_WIDTH(11)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
    .out_ready(out_ready), .win_en(win_en), .win_valid(win_valid), .win_x(win_x), .win_y(win_y),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic end_frame();
    in_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic accept_n(input int n);
    in_valid = 1'b1;
    out_ready = 1'b1;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    #2;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got=%b want=0", busy); end
    compared++; if (in_ready !== 1'b0 || win_en !== 1'b0) begin mismatched++; $display("FAIL reset_ready got=%b/%b want=0/0", in_ready, win_en); end
    compared++; if (win_valid !== 1'b0 || frame_done !== 1'b0) begin mismatched++; $display("FAIL reset_flags got=%b/%b want=0/0", win_valid, frame_done); end
    compared++; if (win_x !== 11'd0 || win_y !== 11'd0) begin mismatched++; $display("FAIL reset_xy got=%0d,%0d want=0,0", win_x, win_y); end
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    tick();
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_full_frame();
    int vcount = 0;
    begin_frame();
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL ff_busy got=%b want=1", busy); end
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      #1;
      compared++; if (win_en !== 1'b1) begin mismatched++; $display("FAIL ff_win_en px=%0d got=%b want=1", i, win_en); end
      tick();
      if (win_valid === 1'b1) vcount++;
      compared++; if (win_valid !== ((i % 8 >= 2) && (i / 8 >= 2))) begin mismatched++; $display("FAIL ff_win_valid px=%0d got=%b want=%b", i, win_valid, (i % 8 >= 2) && (i / 8 >= 2)); end
      compared++; if (win_x !== 11'(i % 8) || win_y !== 11'(i / 8)) begin mismatched++; $display("FAIL ff_xy px=%0d got=%0d,%0d want=%0d,%0d", i, win_x, win_y, i % 8, i / 8); end
      compared++; if (frame_done !== (i == 31)) begin mismatched++; $display("FAIL ff_frame_done px=%0d got=%b want=%b", i, frame_done, i == 31); end
    end
    #1;
    compared++; if (busy !== 1'b1 || in_ready !== 1'b0) begin mismatched++; $display("FAIL ff_done_state got=%b/%b want=1/0", busy, in_ready); end
    in_valid = 1'b0;
    tick();
    compared++; if (frame_done !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL ff_after_done got=%b/%b want=0/0", frame_done, busy); end
    compared++; if (vcount !== 12) begin mismatched++; $display("FAIL ff_valid_count got=%0d want=12", vcount); end
  endtask

  task automatic test_wrap();
    begin_frame();
    accept_n(8);
    compared++; if (win_x !== 11'd7 || win_y !== 11'd0) begin mismatched++; $display("FAIL wrap_last got=%0d,%0d want=7,0", win_x, win_y); end
    accept_n(1);
    compared++; if (win_x !== 11'd0 || win_y !== 11'd1) begin mismatched++; $display("FAIL wrap_next got=%0d,%0d want=0,1", win_x, win_y); end
    end_frame();
  endtask

  task automatic test_stall();
    begin_frame();
    accept_n(11);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      compared++; if (in_ready !== 1'b0 || win_en !== 1'b0) begin mismatched++; $display("FAIL stall_ready cyc=%0d got=%b/%b want=0/0", i, in_ready, win_en); end
      tick();
      compared++; if (win_valid !== 1'b0 || win_x !== 11'd2 || win_y !== 11'd1) begin mismatched++; $display("FAIL stall_hold cyc=%0d got=%b %0d,%0d want=0 2,1", i, win_valid, win_x, win_y); end
    end
    accept_n(1);
    compared++; if (win_x !== 11'd3 || win_y !== 11'd1) begin mismatched++; $display("FAIL stall_resume got=%0d,%0d want=3,1", win_x, win_y); end
    in_valid = 1'b0;
    tick();
    compared++; if (win_valid !== 1'b0 || win_x !== 11'd3) begin mismatched++; $display("FAIL novalid_hold got=%b %0d want=0 3", win_valid, win_x); end
    accept_n(1);
    compared++; if (win_x !== 11'd4 || win_y !== 11'd1) begin mismatched++; $display("FAIL novalid_resume got=%0d,%0d want=4,1", win_x, win_y); end
    end_frame();
  endtask

  task automatic test_abort();
    begin_frame();
    accept_n(20);
    compared++; if (win_x !== 11'd3 || win_y !== 11'd2 || win_valid !== 1'b1) begin mismatched++; $display("FAIL abort_pre got=%0d,%0d %b want=3,2 1", win_x, win_y, win_valid); end
    abort = 1'b1;
    start = 1'b1;
    #1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    compared++; if (busy !== 1'b0 || win_valid !== 1'b0 || frame_done !== 1'b0) begin mismatched++; $display("FAIL abort_state got=%b/%b/%b want=0/0/0", busy, win_valid, frame_done); end
    compared++; if (win_x !== 11'd3 || win_y !== 11'd2) begin mismatched++; $display("FAIL abort_xy got=%0d,%0d want=3,2", win_x, win_y); end
    tick();
    compared++; if (frame_done !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL abort_after got=%b/%b want=0/0", frame_done, busy); end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    begin_frame();
    accept_n(3);
    #2;
    reset = 1'b1;
    #1;
    compared++; if (busy !== 1'b0 || in_ready !== 1'b0 || win_en !== 1'b0) begin mismatched++; $display("FAIL rst_mid_ctrl got=%b/%b/%b want=0/0/0", busy, in_ready, win_en); end
    compared++; if (win_x !== 11'd0 || win_y !== 11'd0 || win_valid !== 1'b0 || frame_done !== 1'b0) begin mismatched++; $display("FAIL rst_mid_out got=%0d,%0d %b %b want=0,0 0 0", win_x, win_y, win_valid, frame_done); end
    tick();
    reset = 1'b0;
    tick();
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_needs_start got=%b want=0", busy); end
    begin_frame();
    #1;
    compared++; if (win_en !== 1'b1) begin mismatched++; $display("FAIL rst_restart_en got=%b want=1", win_en); end
    tick();
    compared++; if (win_x !== 11'd0 || win_y !== 11'd0) begin mismatched++; $display("FAIL rst_restart_xy got=%0d,%0d want=0,0", win_x, win_y); end
    end_frame();
  endtask

  task automatic test_start_ignored();
    begin_frame();
    accept_n(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    compared++; if (win_x !== 11'd3 || win_y !== 11'd0 || busy !== 1'b1) begin mismatched++; $display("FAIL start_ign got=%0d,%0d %b want=3,0 1", win_x, win_y, busy); end
    accept_n(1);
    compared++; if (win_x !== 11'd4 || win_y !== 11'd0) begin mismatched++; $display("FAIL start_ign_next got=%0d,%0d want=4,0", win_x, win_y); end
    end_frame();
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_wrap();
    test_stall();
    test_abort();
    test_reset_mid();
    test_start_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
